// File: rtl/pong_pkg.sv
// Shared types and playfield geometry for the Pong datapath.
//   state_t     : ball engine FSM states
//   dir_t       : one-bit direction, DirLeft/DirRight on x and DirUp/DirDown on y
//   pad_overlap : vertical overlap test between the ball and a paddle
package pong_pkg;

  typedef enum logic [1:0] {StServe, StPlay, StScore, StOver} state_t;

  typedef logic dir_t;
  localparam dir_t DirLeft  = 1'b0;
  localparam dir_t DirRight = 1'b1;
  localparam dir_t DirUp    = 1'b0;
  localparam dir_t DirDown  = 1'b1;

  localparam int unsigned SCR_W   = 640;
  localparam int unsigned SCR_H   = 480;
  localparam int unsigned BALL_SZ = 8;
  localparam int unsigned PAD_H   = 100;
  localparam int unsigned PAD_W   = 8;

  // 11-bit compare so pad_y + PAD_H cannot wrap for any 10-bit paddle position.
  function automatic logic pad_overlap(input logic [9:0] ball_y, input logic [9:0] pad_y);
    logic [10:0] by;
    logic [10:0] py;
    by = {1'b0, ball_y};
    py = {1'b0, pad_y};
    return ((by + 11'(BALL_SZ)) > py) && (by < (py + 11'(PAD_H)));
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running game tick divider with pause.
//   clk, rst_n : clock, synchronous active-low reset
//   pause      : holds the divider and suppresses tick while high
//   tick       : one-clock pulse every 2^TICK_W unpaused clocks
module pong_tick_gen #(
  parameter int unsigned TICK_W = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  output logic tick
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick = !pause && (cnt_q == '1);

  // All-ones wraps to zero on the tick clock by plain overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (!pause) begin
      cnt_d = cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball physics and scoring engine.
//   clk, rst_n         : clock, synchronous active-low reset
//   l_y_pos, r_y_pos   : paddle top y, sampled on tick clocks only
//   pause              : suppresses game ticks
//   ball_x, ball_y     : ball top-left position
//   score_l, score_r   : player scores, saturating at WIN_SCORE via OVER
//   point_l, point_r   : one-clock pulse, coincident with the SCORE state
//   in_play, game_over : FSM in PLAY / OVER
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned TICK_W      = 18,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned LPAD_X      = 20,
  parameter int unsigned RPAD_X      = 612
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] l_y_pos,
  input  logic [9:0] r_y_pos,
  input  logic       pause,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic       in_play,
  output logic       game_over
);

  localparam int unsigned CntW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [9:0] CenterX = 10'((SCR_W - BALL_SZ) / 2);
  localparam logic [9:0] CenterY = 10'((SCR_H - BALL_SZ) / 2);
  localparam logic [9:0] XMax    = 10'(SCR_W - BALL_SZ);
  localparam logic [9:0] YMax    = 10'(SCR_H - BALL_SZ);
  localparam logic [9:0] LHitX   = 10'(LPAD_X + PAD_W);
  localparam logic [9:0] RHitX   = 10'(RPAD_X - BALL_SZ);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_TICKS - 1);
  localparam logic [3:0] WinScore = 4'(WIN_SCORE);

  logic tick;

  pong_tick_gen #(
    .TICK_W(TICK_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .pause(pause),
    .tick (tick)
  );

  state_t          state_q, state_d;
  logic [9:0]      ball_x_q, ball_x_d;
  logic [9:0]      ball_y_q, ball_y_d;
  dir_t            dx_q, dx_d;
  dir_t            dy_q, dy_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic            point_l_q, point_l_d;
  logic            point_r_q, point_r_d;
  logic [CntW-1:0] serve_cnt_q, serve_cnt_d;

  dir_t dx_new, dy_new;
  logic l_scores, r_scores;

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    serve_cnt_d = serve_cnt_q;
    dx_new      = dx_q;
    dy_new      = dy_q;
    l_scores    = 1'b0;
    r_scores    = 1'b0;

    unique case (state_q)
      StServe: begin
        if (tick) begin
          if (serve_cnt_q == ServeLast) begin
            serve_cnt_d = '0;
            state_d     = StPlay;
          end else begin
            serve_cnt_d = serve_cnt_q + CntW'(1);
          end
        end
      end

      StPlay: begin
        if (tick) begin
          if (dy_q == DirUp && ball_y_q == '0) begin
            dy_new = DirDown;
          end else if (dy_q == DirDown && ball_y_q == YMax) begin
            dy_new = DirUp;
          end

          // Paddle face is only tested on the exact contact column, so a ball
          // past the paddle can never be returned from behind.
          if (dx_q == DirLeft) begin
            if (ball_x_q == LHitX && pad_overlap(ball_y_q, l_y_pos)) begin
              dx_new = DirRight;
            end else if (ball_x_q == '0) begin
              r_scores = 1'b1;
            end
          end else begin
            if (ball_x_q == RHitX && pad_overlap(ball_y_q, r_y_pos)) begin
              dx_new = DirLeft;
            end else if (ball_x_q == XMax) begin
              l_scores = 1'b1;
            end
          end

          if (l_scores || r_scores) begin
            ball_x_d = CenterX;
            ball_y_d = CenterY;
            dy_d     = dy_new;
            state_d  = StScore;
            // Serve goes toward the player who conceded.
            if (l_scores) begin
              score_l_d = score_l_q + 4'd1;
              point_l_d = 1'b1;
              dx_d      = DirRight;
            end else begin
              score_r_d = score_r_q + 4'd1;
              point_r_d = 1'b1;
              dx_d      = DirLeft;
            end
          end else begin
            dx_d     = dx_new;
            dy_d     = dy_new;
            ball_x_d = (dx_new == DirRight) ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
            ball_y_d = (dy_new == DirDown)  ? ball_y_q + 10'd1 : ball_y_q - 10'd1;
          end
        end
      end

      StScore: begin
        state_d = (score_l_q == WinScore || score_r_q == WinScore) ? StOver : StServe;
      end

      StOver: begin
      end

      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StServe;
      ball_x_q    <= CenterX;
      ball_y_q    <= CenterY;
      dx_q        <= DirRight;
      dy_q        <= DirDown;
      score_l_q   <= '0;
      score_r_q   <= '0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign in_play   = (state_q == StPlay);
  assign game_over = (state_q == StOver);

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Ball physics and scoring engine for the Pong datapath.
- Consumes the left and right paddle vertical positions produced by the paddle blocks. Advances the ball one pixel per axis per game tick, reflects it off the walls and paddles, and detects misses.
- Drives the ball position to the renderer, and the scores and game-over flag to the score display.

Parameters:
- TICK_W, 18: width of the free-running tick divider. One game tick every 2^TICK_W clocks.
- SCR_W, 640: playfield width in pixels.
- SCR_H, 480: playfield height in pixels.
- BALL_SZ, 8: ball edge length in pixels (square ball).
- PAD_H, 100: paddle height in pixels.
- PAD_W, 8: paddle width in pixels.
- LPAD_X, 20: left paddle left-edge x.
- RPAD_X, 612: right paddle left-edge x.
- SERVE_TICKS, 60: ticks the ball is held at centre before each serve.
- WIN_SCORE, 9: score at which the game ends.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- l_y_pos, input, 10: left paddle top y.
- r_y_pos, input, 10: right paddle top y.
- pause, input, 1: while high, game ticks are suppressed.
- ball_x, output, 10: ball top-left x.
- ball_y, output, 10: ball top-left y.
- score_l, output, 4: left player score.
- score_r, output, 4: right player score.
- point_l, output, 1: one-clock pulse when the left player scores.
- point_r, output, 1: one-clock pulse when the right player scores.
- in_play, output, 1: high while the FSM is in PLAY.
- game_over, output, 1: high while the FSM is in OVER.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low: all state updates on posedge clk, and rst_n is sampled only at that edge. No derived clocks.
- Reset values:
  - ball_x=316, ball_y=236 (centre, (SCR_W-BALL_SZ)/2 and (SCR_H-BALL_SZ)/2).
  - Direction: dx=right, dy=down.
  - score_l = score_r = 0. point_l, point_r, in_play and game_over are all 0.
  - FSM=SERVE, serve counter=0, tick divider=0.
- Tick generation:
  - The divider counts every clock unless pause=1, in which case it holds its value.
  - tick is a one-clock pulse when the divider equals all-ones and pause=0; the divider then wraps to 0.
  - All FSM and position activity occurs only on tick cycles, except the SCORE-state exit, which happens on the next clock regardless of tick.
- FSM states: SERVE, PLAY, SCORE, OVER.
  - SERVE: the ball is held at centre. On each tick the serve counter increments. On the tick where the counter equals SERVE_TICKS-1, clear the counter and go to PLAY. The ball does not move on that tick.
  - PLAY, on each tick, evaluated from the current position and direction, in this order:
    - a) Vertical:
      - If dy=up and ball_y==0, set dy=down.
      - If dy=down and ball_y==SCR_H-BALL_SZ (472), set dy=up.
    - b) Left side, when dx=left:
      - If ball_x==LPAD_X+PAD_W (28) and the ball overlaps the left paddle, set dx=right.
      - Otherwise, if ball_x==0, the right player scores.
    - c) Right side, when dx=right:
      - If ball_x+BALL_SZ==RPAD_X (ball_x=604) and the ball overlaps the right paddle, set dx=left.
      - Otherwise, if ball_x==SCR_W-BALL_SZ (632), the left player scores.
    - d) If no score occurred, move one pixel in each axis using the updated dx/dy.
    - On a score: do not move. Increment the scorer's score, pulse point_x, recentre the ball, set dx toward the conceding player, keep dy, and go to SCORE.
  - Overlap test: ball_y+BALL_SZ > pad_y AND ball_y < pad_y+PAD_H. Evaluate in 11-bit unsigned arithmetic; no truncation.
  - Corner case: a wall bounce and a paddle bounce on the same tick both flip their directions, and the move uses both flipped directions.
  - Between paddle column and wall: a ball that passes x=28 unhit continues to 0. There is no re-hit from behind the paddle.
  - SCORE: lasts one clock. If the updated score equals WIN_SCORE, go to OVER; else go to SERVE.
  - OVER: everything frozen. Exit only via reset.
- Output timing: all outputs are registered. point_l and point_r assert in the clock after the scoring tick, for exactly one clock, coincident with state=SCORE.
- Scores never exceed WIN_SCORE.
- Paddle inputs are sampled combinationally on tick cycles only. Values above SCR_H-PAD_H are used as given.
- Reset asserted mid-play or mid-serve returns to all reset values on the next edge.

Decomposition:
- Package pong_pkg holds:
  - state_t enum (SERVE, PLAY, SCORE, OVER);
  - dir_t (1-bit, LEFT/RIGHT and UP/DOWN aliases);
  - playfield constants SCR_W, SCR_H, BALL_SZ, PAD_H and PAD_W.
- One sub-module, pong_tick_gen: parameterised divider with a pause input, producing the tick pulse. It is reusable by the paddle blocks.

Test Plan:
- Reset and serve, with TICK_W=2 and SERVE_TICKS=3: release reset, hold paddles away from the ball path. Expect ball stays at (316,236) for 3 ticks, then in_play=1. The first PLAY tick gives (317,237).
- Bottom wall: force the ball to (400,471) moving down-right. Expect (401,472), then dy flips, then (402,471).
- Left paddle hit: l_y_pos=100, ball at (29,150) moving left-up. Expect (28,149), then a bounce to (29,148) with dx=right.
- Left miss: l_y_pos=300, ball reaches x=0 at y=50. Expect point_r for one clock, score_r=1, ball recentred, dx=left, then a SERVE hold of SERVE_TICKS.
- Pause: hold pause high for 20 clocks mid-PLAY. Expect ball_x and ball_y unchanged and the divider frozen; movement resumes on the first tick after release.
- Game over with WIN_SCORE=2: two left misses. Expect score_r=2 and game_over=1 with everything frozen; a reset pulse restores all reset values.
